uart_debug_sched: RTL and testbench
===================================

UART_DEBUG_SCHED -- requirements
Module: uart_debug_sched

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 1024, trace sample interval in wb_clk_i cycles (legal 4..65535).
REQ-002 wb_clk_i  input  1  single clock; all logic rising-edge.
REQ-003 wb_rst_i  input  1  synchronous, active-high reset.
REQ-004 wb_stb_i  input  1  host debug-read request, held until wb_ack_o.
REQ-005 wb_adr_i  input  `UART_ADDR_WIDTH  host debug address, stable while wb_stb_i high.
REQ-006 wb_ack_o  output  1  one-cycle host completion pulse.
REQ-007 wb_dat32_o  output  32  host read data, valid with wb_ack_o and held until the next ack.
REQ-008 dbg_adr_o  output  `UART_ADDR_WIDTH  registered address to the debug register mux.
REQ-009 dbg_dat32_i  input  32  combinational debug mux data for dbg_adr_o.
REQ-010 tr_en_i  input  1  trace sampler enable.
REQ-011 tr_valid_o  output  1  trace record valid.
REQ-012 tr_ready_i  input  1  trace consumer ready.
REQ-013 tr_data_o  output  64  trace record: [31:0] word at 5'h08, [63:32] word at 5'h0C.
REQ-014 tr_overrun_o  output  8  saturating count of dropped sample ticks.

Function
REQ-015 The block SHALL share the single debug mux port between the host and the trace sampler through FSM states IDLE, HOST, TR_A and TR_B.
REQ-016 IDLE SHALL grant the sampler when the pending flag is set and (no host request or last_grant == HOST), else grant the host when wb_stb_i is high and wb_ack_o is low; the granted requester is recorded in last_grant.
REQ-017 A host grant SHALL load dbg_adr_o <= wb_adr_i and enter HOST; HOST SHALL load wb_dat32_o <= dbg_dat32_i, pulse wb_ack_o for one cycle and return to IDLE (stb sampled at cycle N in IDLE -> ack at N+2).
REQ-018 IDLE SHALL ignore wb_stb_i in any cycle where wb_ack_o is high, so a held stb is not re-granted.
REQ-019 A sampler grant SHALL clear pending, load dbg_adr_o <= 5'h08 and enter TR_A.
REQ-020 TR_A SHALL capture tr_data_o[31:0] and load dbg_adr_o <= 5'h0C; TR_B SHALL capture tr_data_o[63:32], set tr_valid_o and return to IDLE. The two words are read in consecutive cycles with no host access between them.
REQ-021 tr_valid_o SHALL stay high with tr_data_o stable until a cycle with tr_ready_i high, and SHALL clear on that cycle.
REQ-022 While tr_en_i is high, a period counter SHALL count 0..SAMPLE_PERIOD-1 and wrap, issuing a tick on the terminal count.
REQ-023 A tick SHALL set pending unless pending is already set or tr_valid_o is high; in that case the tick is dropped and tr_overrun_o increments, saturating at 255.
REQ-024 tr_en_i low SHALL clear the counter and pending, SHALL NOT abort TR_A/TR_B in progress, and SHALL NOT clear tr_valid_o or tr_overrun_o.
REQ-025 Simultaneous tick and tr_valid_o handshake in the same cycle SHALL set pending (the handshake takes precedence).
REQ-026 Worst-case host latency SHALL be 5 cycles from stb to ack: one sampler pair plus the host access.

Reset
REQ-027 wb_rst_i high SHALL force state IDLE, last_grant HOST, pending 0, counter 0, wb_ack_o 0, wb_dat32_o 0, dbg_adr_o 0, tr_valid_o 0, tr_data_o 0, tr_overrun_o 0.
REQ-028 Reset mid-transaction SHALL abandon it: no ack and no trace record is produced for it.

Configuration
REQ-029 With macro UART_DEBUG_TRACE_EN defined, the sampler, counter, pending flag and round-robin logic SHALL be present.
REQ-030 Without UART_DEBUG_TRACE_EN, the block SHALL serve only the host, using IDLE and HOST only. tr_valid_o, tr_data_o and tr_overrun_o SHALL be constant 0, and tr_en_i and tr_ready_i SHALL be ignored.

Verification
REQ-031 Host only: stb with adr 5'h0C and dbg_dat32_i 32'hA5A5_0003 -> ack exactly 2 cycles later with wb_dat32_o 32'hA5A5_0003 and dbg_adr_o 5'h0C.
REQ-032 Sampler: SAMPLE_PERIOD 8, tr_en_i 1, tr_ready_i 1, mux returns 32'h1111_1111 at 5'h08 and 32'h2222_2222 at 5'h0C -> tr_data_o 64'h2222_2222_1111_1111, valid 3 cycles after tick, repeating every 8 cycles.
REQ-033 Contention: host stb held continuously and a tick occurs -> grants alternate host/sampler, and no host wait exceeds 5 cycles.
REQ-034 Backpressure: tr_ready_i 0 across 300 ticks -> single record held stable and tr_overrun_o saturates at 255.
REQ-035 Reset in TR_A: wb_rst_i pulse -> all outputs 0 next cycle and no record is emitted.
REQ-036 Build without UART_DEBUG_TRACE_EN: tr_en_i 1 for 100 cycles -> tr_valid_o stays 0 and host reads behave as in REQ-031.

Source files
------------

// File: rtl/uart_debug_sched.sv
// uart_debug_sched: shares one debug-register mux port between a host read
// port and a periodic trace sampler that reads a 64-bit record (two words).
// Optional feature macro: UART_DEBUG_TRACE_EN. When it is defined, the
// sampler, period counter, pending flag and round-robin grant are built in.
// Without it only the host is served and the trace outputs are tied to 0.

`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 5
`endif

module uart_debug_sched #(
    parameter int unsigned SAMPLE_PERIOD = 1024
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wb_stb_i,
    input  logic [`UART_ADDR_WIDTH-1:0] wb_adr_i,
    output logic                        wb_ack_o,
    output logic [31:0]                 wb_dat32_o,
    output logic [`UART_ADDR_WIDTH-1:0] dbg_adr_o,
    input  logic [31:0]                 dbg_dat32_i,
    input  logic                        tr_en_i,
    output logic                        tr_valid_o,
    input  logic                        tr_ready_i,
    output logic [63:0]                 tr_data_o,
    output logic [7:0]                  tr_overrun_o
);

    localparam int unsigned AW = `UART_ADDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StHost,
        StTrA,
        StTrB
    } state_e;

    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          host_req;

    // A held strobe is not seen during the ack cycle, so it is served only once.
    assign host_req = wb_stb_i && !ack_q;

`ifdef UART_DEBUG_TRACE_EN
    localparam logic [AW-1:0] AdrTrLo = AW'(8);
    localparam logic [AW-1:0] AdrTrHi = AW'(12);
    localparam logic [15:0]   CntLast = 16'(SAMPLE_PERIOD - 1);

    logic        last_host_q, last_host_d;
    logic        pending_q, pending_d;
    logic [15:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [63:0] trdata_q, trdata_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        tick;
    logic        handshake;
    logic        smp_req;

    assign tick      = tr_en_i && (cnt_q == CntLast);
    assign handshake = valid_q && tr_ready_i;
    // Never start a new capture while an unaccepted record is still on tr_data_o.
    assign smp_req   = pending_q && (!valid_q || tr_ready_i);
`endif

    // Next-state: arbitration FSM, host read path and trace sampler bookkeeping.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        adr_d   = adr_q;
`ifdef UART_DEBUG_TRACE_EN
        last_host_d = last_host_q;
        pending_d   = pending_q;
        trdata_d    = trdata_q;
        ovr_d       = ovr_q;
        valid_d     = handshake ? 1'b0 : valid_q;

        if (!tr_en_i || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        // A tick landing on an accepted record is not a drop.
        if (tick) begin
            if (pending_q || (valid_q && !tr_ready_i)) begin
                if (ovr_q != 8'hFF) begin
                    ovr_d = ovr_q + 8'd1;
                end
            end else begin
                pending_d = 1'b1;
            end
        end
`endif

        unique case (state_q)
            StIdle: begin
`ifdef UART_DEBUG_TRACE_EN
                if (smp_req && (!host_req || last_host_q)) begin
                    pending_d   = 1'b0;
                    last_host_d = 1'b0;
                    adr_d       = AdrTrLo;
                    state_d     = StTrA;
                end else
`endif
                if (host_req) begin
                    adr_d   = wb_adr_i;
                    state_d = StHost;
`ifdef UART_DEBUG_TRACE_EN
                    last_host_d = 1'b1;
`endif
                end
            end
            StHost: begin
                dat_d   = dbg_dat32_i;
                ack_d   = 1'b1;
                state_d = StIdle;
            end
`ifdef UART_DEBUG_TRACE_EN
            StTrA: begin
                trdata_d[31:0] = dbg_dat32_i;
                adr_d          = AdrTrHi;
                state_d        = StTrB;
            end
            StTrB: begin
                trdata_d[63:32] = dbg_dat32_i;
                valid_d         = 1'b1;
                state_d         = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase

`ifdef UART_DEBUG_TRACE_EN
        // Disabling the sampler drops any queued request but not a capture in flight.
        if (!tr_en_i) begin
            pending_d = 1'b0;
        end
`endif
    end

    // FSM state and registered host-side outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            adr_q   <= adr_d;
        end
    end

`ifdef UART_DEBUG_TRACE_EN
    // Trace sampler registers: grant history, pending flag, counter and record.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last_host_q <= 1'b1;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            trdata_q    <= '0;
            ovr_q       <= '0;
        end else begin
            last_host_q <= last_host_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            trdata_q    <= trdata_d;
            ovr_q       <= ovr_d;
        end
    end

    assign tr_valid_o   = valid_q;
    assign tr_data_o    = trdata_q;
    assign tr_overrun_o = ovr_q;
`else
    logic unused_trace;
    assign unused_trace = tr_en_i ^ tr_ready_i ^ (SAMPLE_PERIOD == 0);

    assign tr_valid_o   = 1'b0;
    assign tr_data_o    = '0;
    assign tr_overrun_o = '0;
`endif

    assign wb_ack_o   = ack_q;
    assign wb_dat32_o = dat_q;
    assign dbg_adr_o  = adr_q;

endmodule

// File: tb/tb_uart_debug_sched.sv
// Bench for uart_debug_sched: random host reads against a register-array model,
// plus directed sampler, contention, backpressure and reset scenarios when the
// trace feature (UART_DEBUG_TRACE_EN) is compiled in.

module tb_uart_debug_sched;

    localparam int unsigned AW     = `UART_ADDR_WIDTH;
    localparam int          Period = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          stb;
    logic [AW-1:0] adr;
    logic          ack;
    logic [31:0]   dat;
    logic [AW-1:0] dbg_adr;
    logic [31:0]   dbg_dat;
    logic          tr_en;
    logic          tr_valid;
    logic          tr_ready;
    logic [63:0]   tr_data;
    logic [7:0]    tr_ovr;

    logic [31:0]   regs [2**AW];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Debug register mux model: combinational read of the register array.
    assign dbg_dat = regs[dbg_adr];

    uart_debug_sched #(
        .SAMPLE_PERIOD(Period)
    ) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb_stb_i    (stb),
        .wb_adr_i    (adr),
        .wb_ack_o    (ack),
        .wb_dat32_o  (dat),
        .dbg_adr_o   (dbg_adr),
        .dbg_dat32_i (dbg_dat),
        .tr_en_i     (tr_en),
        .tr_valid_o  (tr_valid),
        .tr_ready_i  (tr_ready),
        .tr_data_o   (tr_data),
        .tr_overrun_o(tr_ovr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        stb      = 1'b0;
        tr_en    = 1'b0;
        tr_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // One host read on an otherwise quiet block: ack two cycles after the strobe.
    task automatic host_read(input logic [AW-1:0] a, input bit late_drop);
        logic [31:0] exp_dat;
        int lat;
        exp_dat = regs[a];
        lat     = 0;
        adr     = a;
        stb     = 1'b1;
        do begin
            cyc();
            lat++;
        end while (ack !== 1'b1 && lat < 20);
        check("host_latency", 64'(lat), 64'd2);
        check("host_data", 64'(dat), 64'(exp_dat));
        check("host_dbg_adr", 64'(dbg_adr), 64'(a));
        if (late_drop) begin
            cyc();
            check("ack_one_cycle", 64'(ack), 64'd0);
        end
        stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("no_regrant", 64'(ack), 64'd0);
            check("data_held", 64'(dat), 64'(exp_dat));
        end
    endtask

`ifdef UART_DEBUG_TRACE_EN
    // Free-running sampler with an always-ready consumer: first record three
    // cycles after the first tick (cycle Period), then one every Period cycles.
    task automatic trace_run(input int n_cyc, input int exp_recs);
        int next_c;
        int recs;
        next_c = Period + 3;
        recs   = 0;
        tr_en  = 1'b1;
        for (int c = 1; c <= n_cyc; c++) begin
            cyc();
            if (tr_valid === 1'b1) begin
                check("tr_timing", 64'(c), 64'(next_c));
                check("tr_data", tr_data, {regs[12], regs[8]});
                next_c = next_c + Period;
                recs++;
            end
        end
        check("tr_count", 64'(recs), 64'(exp_recs));
        tr_en = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [63:0]   rec;
        logic [31:0]   exp_dat;
        int            since;
        int            lim;
        int            n_rec;
        int            n_host;
        bit            seen;

        for (int i = 0; i < 2**AW; i++) begin
            regs[i] = $urandom;
        end
        rst = 1'b1; stb = 1'b0; adr = '0; tr_en = 1'b0; tr_ready = 1'b0;

        // Reset state.
        do_reset();
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_dat", 64'(dat), 64'd0);
        check("rst_dbg_adr", 64'(dbg_adr), 64'd0);
        check("rst_tr_valid", 64'(tr_valid), 64'd0);
        check("rst_tr_data", tr_data, 64'd0);
        check("rst_tr_ovr", 64'(tr_ovr), 64'd0);

        // Directed host read.
        regs[12] = 32'hA5A5_0003;
        host_read(AW'(12), 1'b1);

        // Random host reads; trace inputs randomised when the sampler is absent.
        for (int i = 0; i < 24; i++) begin
            a       = AW'($urandom_range(0, 2**AW - 1));
            regs[a] = $urandom;
`ifndef UART_DEBUG_TRACE_EN
            tr_en    = 1'($urandom_range(0, 1));
            tr_ready = 1'($urandom_range(0, 1));
`endif
            host_read(a, 1'($urandom_range(0, 1)));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                cyc();
            end
        end

`ifdef UART_DEBUG_TRACE_EN
        // Periodic sampling, then restart after the sampler is disabled.
        do_reset();
        regs[8]  = 32'h1111_1111;
        regs[12] = 32'h2222_2222;
        tr_ready = 1'b1;
        trace_run(60, 7);
        cyc(); cyc(); cyc();
        trace_run(30, 3);

        // Contention: host strobe held continuously while the sampler ticks.
        do_reset();
        tr_ready = 1'b1;
        tr_en    = 1'b1;
        a        = AW'($urandom_range(0, 2**AW - 1));
        exp_dat  = regs[a];
        adr      = a;
        stb      = 1'b1;
        since    = 0;
        lim      = 5;
        n_rec    = 0;
        n_host   = 0;
        for (int c = 1; c <= 200; c++) begin
            cyc();
            since++;
            if (tr_valid === 1'b1) begin
                check("cont_tr_data", tr_data, 64'h2222_2222_1111_1111);
                n_rec++;
            end
            if (ack === 1'b1) begin
                check("cont_host_data", 64'(dat), 64'(exp_dat));
                check("cont_host_wait_ok", 64'(since <= lim), 64'd1);
                n_host++;
                since   = 0;
                lim     = 6;
                a       = AW'($urandom_range(0, 2**AW - 1));
                exp_dat = regs[a];
                adr     = a;
            end
        end
        stb = 1'b0;
        check("cont_records", 64'(n_rec >= 23), 64'd1);
        check("cont_host_reads", 64'(n_host >= 30), 64'd1);
        check("cont_no_overrun", 64'(tr_ovr), 64'd0);

        // Backpressure: one record held, dropped ticks counted and saturated.
        do_reset();
        regs[8]  = 32'h1111_1111;
        tr_en    = 1'b1;
        rec      = 64'h2222_2222_1111_1111;
        for (int c = 1; c <= 2460; c++) begin
            cyc();
            if (c == Period + 3) begin
                check("bp_first_valid", 64'(tr_valid), 64'd1);
                check("bp_first_data", tr_data, rec);
            end
            if (c > Period + 3 && c < 2448 && (c % 50) == 0) begin
                check("bp_valid_held", 64'(tr_valid), 64'd1);
                check("bp_data_stable", tr_data, rec);
            end
            if (c == 79)   check("bp_ovr_8", 64'(tr_ovr), 64'd8);
            if (c == 80)   check("bp_ovr_9", 64'(tr_ovr), 64'd9);
            if (c == 2047) check("bp_ovr_254", 64'(tr_ovr), 64'd254);
            if (c == 2048) check("bp_ovr_255", 64'(tr_ovr), 64'd255);
            if (c == 2100) check("bp_ovr_sat", 64'(tr_ovr), 64'd255);
            if (c == 2400) regs[8] = 32'h3333_3333;
            if (c == 2447) tr_ready = 1'b1;
            if (c == 2448) begin
                check("bp_hs_on_tick_clear", 64'(tr_valid), 64'd0);
                tr_ready = 1'b0;
            end
            if (c == 2451) begin
                check("bp_hs_on_tick_rec", 64'(tr_valid), 64'd1);
                check("bp_hs_on_tick_data", tr_data, 64'h2222_2222_3333_3333);
                tr_en = 1'b0;
            end
        end
        check("bp_en_off_valid", 64'(tr_valid), 64'd1);
        check("bp_en_off_ovr", 64'(tr_ovr), 64'd255);
        tr_ready = 1'b1;
        cyc();
        check("bp_release", 64'(tr_valid), 64'd0);

        // Reset while the second capture is in its first word.
        do_reset();
        regs[8]  = 32'h1111_1111;
        tr_ready = 1'b1;
        tr_en    = 1'b1;
        for (int c = 1; c <= 2 * Period + 1; c++) begin
            cyc();
            if (c == Period + 3) check("tra_first_rec", 64'(tr_valid), 64'd1);
        end
        check("tra_in_capture", 64'(dbg_adr), 64'd8);
        rst = 1'b1;
        cyc();
        check("tra_rst_ack", 64'(ack), 64'd0);
        check("tra_rst_dat", 64'(dat), 64'd0);
        check("tra_rst_adr", 64'(dbg_adr), 64'd0);
        check("tra_rst_valid", 64'(tr_valid), 64'd0);
        check("tra_rst_data", tr_data, 64'd0);
        check("tra_rst_ovr", 64'(tr_ovr), 64'd0);
        rst   = 1'b0;
        tr_en = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (tr_valid !== 1'b0) seen = 1'b1;
        end
        check("tra_no_record", 64'(seen), 64'd0);
`else
        // Sampler absent: trace inputs have no effect, host path unchanged.
        do_reset();
        tr_en = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tr_ready = 1'($urandom_range(0, 1));
            cyc();
            if (tr_valid !== 1'b0 || tr_data !== 64'd0 || tr_ovr !== 8'd0) seen = 1'b1;
        end
        check("notrace_outputs_zero", 64'(seen), 64'd0);
        regs[12] = 32'hA5A5_0003;
        host_read(AW'(12), 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
